// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals of the two-requester ALU arbiter.
// The arbiter takes the slave side; requesters, ALU and response consumer take the master side.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
);
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   alu_ctrl;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    logic [15:0]       ops_count;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output alu_ctrl, alu_a, alu_b,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, ops_count,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  alu_ctrl, alu_a, alu_b,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, ops_count,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: grant, execute, respond; one op per 3 cycles, response held until rsp_ready.
// No grant while an op is in flight. Macro ALU_ARB_FIXED_PRIO_EN selects fixed req0 priority instead of round-robin.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic         Clk,
    input  logic         Rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic              id_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              rsp_valid_q;
    logic              rsp_zero_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic [15:0]       ops_cnt_q;
    logic [15:0]       ops_cnt_d;
    logic              grant0;
    logic              grant1;
    logic              op_legal;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic              ptr_q;
`endif

    // Grants are combinational on the current valids so a requester that
    // withdraws before being granted is never latched.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (Rst_n && state_q == S_IDLE) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid && !bus.req0_valid;
`else
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = !ptr_q;
                grant1 = ptr_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
`endif
        end
    end

    assign op_legal  = (op_q <= OP_W'(9)) || ((op_q >= OP_W'(14)) && (op_q <= OP_W'(20)));
    assign ops_cnt_d = ops_cnt_q + 16'd1;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q      <= S_IDLE;
            id_q         <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            ops_cnt_q    <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        id_q    <= grant1;
                        op_q    <= grant1 ? bus.req1_op : bus.req0_op;
                        a_q     <= grant1 ? bus.req1_a  : bus.req0_a;
                        b_q     <= grant1 ? bus.req1_b  : bus.req0_b;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        ptr_q   <= !ptr_q;
`endif
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result_q <= bus.alu_result;
                    rsp_zero_q   <= bus.alu_zero;
                    rsp_err_q    <= !op_legal;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ops_cnt_q   <= ops_cnt_d;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.alu_ctrl   = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.ops_count  = ops_cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int OW = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(DW), .OP_W(OW)) bus ();

    alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Stand-in for the shared ALU; illegal codes produce 0.
    function automatic logic [31:0] alu_model(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            5'h00:   return a + b;
            5'h01:   return a - b;
            5'h02:   return a & b;
            5'h03:   return a | b;
            5'h04:   return a ^ b;
            5'h05:   return a << b[4:0];
            5'h06:   return a >> b[4:0];
            5'h07:   return ~(a | b);
            5'h08:   return (a < b) ? 32'd1 : 32'd0;
            5'h09:   return a;
            5'h0E, 5'h0F, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14:
                     return a + b + {27'd0, op};
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit op_ok(logic [4:0] op);
        return (op <= 5'h09) || (op >= 5'h0E && op <= 5'h14);
    endfunction

    assign bus.alu_result = alu_model(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    assign bus.alu_zero   = (bus.alu_result == 32'd0);

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Present one request and wait (bounded) for its grant; returns at the negedge after the handshake.
    task automatic run_op(input bit id, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, output bit ok);
        ok = 1'b0;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (id ? bus.req1_ready : bus.req0_ready) ok = 1'b1;
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_op = 5'($urandom); bus.req0_a = $urandom; bus.req0_b = $urandom;
        bus.req1_op = 5'($urandom); bus.req1_a = $urandom; bus.req1_b = $urandom;
    endtask

    task automatic test_reset();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp_ready  = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
                n_bad++; $display("FAIL reset_ready: got %b expected 00", {bus.req1_ready, bus.req0_ready});
            end
        end
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_zero, bus.rsp_err} !== 3'b000) begin
            n_bad++; $display("FAIL reset_rsp_flags: got %b expected 000", {bus.rsp_valid, bus.rsp_zero, bus.rsp_err});
        end
        n_cmp++;
        if ({bus.alu_ctrl, bus.alu_a, bus.alu_b} !== 69'd0) begin
            n_bad++; $display("FAIL reset_alu: got ctrl=%h a=%h b=%h expected 0", bus.alu_ctrl, bus.alu_a, bus.alu_b);
        end
        n_cmp++;
        if ({bus.ops_count, bus.rsp_result} !== 48'd0) begin
            n_bad++; $display("FAIL reset_count_result: got cnt=%h res=%h expected 0", bus.ops_count, bus.rsp_result);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        bit ok;
        bus.rsp_ready = 1'b1;
        run_op(1'b0, 5'h00, 32'd5, 32'd7, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_grant: got no grant expected grant"); end
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_exec_valid: got %b expected 0", bus.rsp_valid);
        end
        tick();
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_err, bus.rsp_result} !== {4'b1000, 32'd12}) begin
            n_bad++; $display("FAIL single_rsp: got v=%b id=%b z=%b e=%b res=%0d expected v=1 id=0 z=0 e=0 res=12",
                              bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_err, bus.rsp_result);
        end
        tick();
        n_cmp++;
        if ({bus.rsp_valid, bus.ops_count} !== {1'b0, 16'd1}) begin
            n_bad++; $display("FAIL single_done: got v=%b cnt=%0d expected v=0 cnt=1", bus.rsp_valid, bus.ops_count);
        end
    endtask

    task automatic test_contention();
        bit got[4];
        bit exp[4];
        int ng = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        do_reset();
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 5'h02; bus.req0_a = $urandom; bus.req0_b = $urandom;
        bus.req1_valid = 1'b1; bus.req1_op = 5'h03; bus.req1_a = $urandom; bus.req1_b = $urandom;
        #1;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            if (bus.req0_ready || bus.req1_ready) begin
                n_cmp++;
                if (bus.req0_ready && bus.req1_ready) begin
                    n_bad++; $display("FAIL contention_onehot: got both readies expected one");
                end
                got[ng] = bus.req1_ready;
                ng++;
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= ng || got[i] !== exp[i]) begin
                n_bad++; $display("FAIL contention_grant%0d: got %0d (grants seen %0d) expected %0d",
                                  i, (i < ng) ? int'(got[i]) : -1, ng, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        bus.rsp_ready = 1'b0;
        run_op(1'b0, 5'h01, 32'd3, 32'd3, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL bp_grant: got no grant expected grant"); end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({bus.rsp_valid, bus.rsp_zero, bus.rsp_result, bus.req0_ready, bus.req1_ready} !== {2'b11, 32'd0, 2'b00}) begin
                n_bad++; $display("FAIL bp_hold%0d: got v=%b z=%b res=%h rdy=%b%b expected v=1 z=1 res=0 rdy=00",
                                  i, bus.rsp_valid, bus.rsp_zero, bus.rsp_result, bus.req1_ready, bus.req0_ready);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
            n_bad++; $display("FAIL bp_no_bypass: got rdy=%b%b expected 00", bus.req1_ready, bus.req0_ready);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        n_cmp++;
        if ({bus.rsp_valid, bus.ops_count} !== {1'b0, 16'd1}) begin
            n_bad++; $display("FAIL bp_release: got v=%b cnt=%0d expected v=0 cnt=1", bus.rsp_valid, bus.ops_count);
        end
    endtask

    task automatic test_illegal_op();
        logic [4:0]  tbl[7] = '{5'h0A, 5'h09, 5'h0D, 5'h0E, 5'h14, 5'h15, 5'h1F};
        logic [31:0] a, b, res;
        bit          id, ok;
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a  = $urandom;
            b  = $urandom;
            id = 1'($urandom);
            res = alu_model(tbl[i], a, b);
            run_op(id, tbl[i], a, b, ok);
            tick();
            n_cmp++;
            if (!ok || {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result} !== {1'b1, id, !op_ok(tbl[i]), res}) begin
                n_bad++; $display("FAIL opcode_%h: got v=%b id=%b err=%b res=%h expected v=1 id=%b err=%b res=%h",
                                  tbl[i], bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result, id, !op_ok(tbl[i]), res);
            end
            tick();
        end
        n_cmp++;
        if (bus.ops_count !== 16'd7) begin
            n_bad++; $display("FAIL opcode_count: got %0d expected 7", bus.ops_count);
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        do_reset();
        bus.rsp_ready = 1'b1;
        run_op(1'b0, 5'h00, 32'd1, 32'd2, ok);
        tick();
        tick();
        run_op(1'b1, 5'h00, 32'd8, 32'd9, ok);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req0_valid = 1'b1;
        #1;
        n_cmp++;
        if ({bus.rsp_valid, bus.ops_count, bus.req0_ready} !== {1'b0, 16'd0, 1'b1}) begin
            n_bad++; $display("FAIL midreset_state: got v=%b cnt=%0d rdy0=%b expected v=0 cnt=0 rdy0=1",
                              bus.rsp_valid, bus.ops_count, bus.req0_ready);
        end
        bus.req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (bus.rsp_valid !== 1'b0) begin
                n_bad++; $display("FAIL midreset_no_rsp%0d: got v=1 expected 0", i);
            end
        end
    endtask

    task automatic test_counter_wrap();
        bit ok;
        logic [15:0] exp_cnt[2] = '{16'hFFFF, 16'h0000};
        bus.rsp_ready = 1'b1;
        force dut.ops_cnt_q = 16'hFFFE;
        tick();
        release dut.ops_cnt_q;
        for (int i = 0; i < 2; i++) begin
            run_op(1'($urandom), 5'h04, $urandom, $urandom, ok);
            tick();
            tick();
            n_cmp++;
            if (!ok || bus.ops_count !== exp_cnt[i]) begin
                n_bad++; $display("FAIL wrap_count%0d: got %h expected %h", i, bus.ops_count, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_random();
        bit          pend[2] = '{1'b0, 1'b0};
        logic [4:0]  rop[2];
        logic [31:0] ra[2];
        logic [31:0] rb[2];
        bit          ptr = 1'b0;
        bit          busy = 1'b0;
        int          age = 0;
        logic [15:0] cnt = 16'd0;
        bit          exp_id = 1'b0;
        logic [31:0] exp_res = 32'd0;
        bit          exp_err = 1'b0;
        bit          w_any, w_id, exp_v;
        logic [1:0]  exp_rdy;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (pend[r] && $urandom_range(7) == 0) pend[r] = 1'b0;
                else if (!pend[r] && $urandom_range(1) == 0) begin
                    pend[r] = 1'b1;
                    rop[r] = 5'($urandom);
                    ra[r] = $urandom;
                    rb[r] = ($urandom_range(3) == 0) ? ra[r] : $urandom;
                end
            end
            bus.req0_valid = pend[0]; bus.req0_op = rop[0]; bus.req0_a = ra[0]; bus.req0_b = rb[0];
            bus.req1_valid = pend[1]; bus.req1_op = rop[1]; bus.req1_a = ra[1]; bus.req1_b = rb[1];
            bus.rsp_ready  = ($urandom_range(9) < 7);
            #1;
            w_any = !busy && (pend[0] || pend[1]);
`ifdef ALU_ARB_FIXED_PRIO_EN
            w_id = !pend[0];
`else
            w_id = (pend[0] && pend[1]) ? ptr : pend[1];
`endif
            exp_rdy = w_any ? (w_id ? 2'b10 : 2'b01) : 2'b00;
            exp_v   = busy && (age >= 1);
            n_cmp++;
            if ({bus.req1_ready, bus.req0_ready} !== exp_rdy) begin
                n_bad++; $display("FAIL rand_ready c=%0d: got %b%b expected %b", c, bus.req1_ready, bus.req0_ready, exp_rdy);
            end
            n_cmp++;
            if ({bus.rsp_valid, bus.ops_count} !== {exp_v, cnt}) begin
                n_bad++; $display("FAIL rand_valid_count c=%0d: got v=%b cnt=%h expected v=%b cnt=%h",
                                  c, bus.rsp_valid, bus.ops_count, exp_v, cnt);
            end
            if (exp_v && bus.rsp_ready) begin
                n_cmp++;
                if ({bus.rsp_id, bus.rsp_err, bus.rsp_zero, bus.rsp_result} !== {exp_id, exp_err, exp_res == 32'd0, exp_res}) begin
                    n_bad++; $display("FAIL rand_rsp c=%0d: got id=%b err=%b z=%b res=%h expected id=%b err=%b res=%h",
                                      c, bus.rsp_id, bus.rsp_err, bus.rsp_zero, bus.rsp_result, exp_id, exp_err, exp_res);
                end
            end
            if (w_any) begin
                busy    = 1'b1;
                age     = 0;
                exp_id  = w_id;
                exp_res = alu_model(rop[w_id], ra[w_id], rb[w_id]);
                exp_err = !op_ok(rop[w_id]);
                ptr     = !ptr;
                pend[w_id] = 1'b0;
            end else if (exp_v && bus.rsp_ready) begin
                busy = 1'b0;
                cnt  = cnt + 16'd1;
            end else if (busy) begin
                age++;
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_illegal_op();
        test_reset_mid_op();
        test_counter_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
